// File: rtl/bcd_to_bin_dabble_pkg.sv
// Shared definitions for the double-dabble converter family (BCD<->binary).
package bcd_to_bin_dabble_pkg;

  // FSM encodings shared with the binary-to-BCD block
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } dabble_state_t;

  localparam int         BCD_DIGIT_W = 4;
  // Correction applied per digit: reverse direction subtracts it at >= 8,
  // forward (binary-to-BCD) direction adds it at >= 5.
  localparam logic [3:0] DABBLE_CORR       = 4'd3;
  localparam logic [3:0] DABBLE_SUB_THRESH = 4'd8;
  localparam logic [3:0] DABBLE_ADD_THRESH = 4'd5;

  // A packed BCD digit is legal only in the range 0..9
  function automatic logic digit_is_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_bin_dabble_digit_sub3.sv
// One BCD digit correction cell for the reverse double-dabble shift.
module bcd_digit_sub3
  import bcd_to_bin_dabble_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // After a right shift a digit >= 8 carried a half-ten from the digit above; remove the excess 3
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= DABBLE_SUB_THRESH)
      digit_out = digit_in - DABBLE_CORR;
  end

endmodule

// File: rtl/bcd_to_bin_dabble.sv
// Iterative reverse double-dabble: packed BCD in, unsigned binary out, one bit per clock.
module bcd_to_bin_dabble
  import bcd_to_bin_dabble_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                            busy,
  output logic                            done,
  output logic [BIN_W-1:0]                bin_out,
  output logic                            invalid
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  dabble_state_t    state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [BCD_W-1:0] bcd_reg, bcd_shift, bcd_nxt;
  logic [BIN_W-1:0] bin_reg, bin_nxt;
  logic             in_valid;
  logic             accept;
  logic             last_iter;

  assign bcd_shift = bcd_reg >> 1;
  assign bin_nxt   = {bcd_reg[0], bin_reg[BIN_W-1:1]};
  assign last_iter = (count == LAST_ITER);
  assign accept    = (state == ST_IDLE) && start;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit_in  (bcd_shift[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_nxt[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Flag any illegal digit in the presented input
  always_comb begin
    in_valid = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (!digit_is_valid(bcd_in[d*BCD_DIGIT_W +: BCD_DIGIT_W]))
        in_valid = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = in_valid ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Iteration counter and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      bin_out <= '0;
      invalid <= 1'b0;
    end else if (accept) begin
      count <= '0;
      if (in_valid) begin
        invalid <= 1'b0;
      end else begin
        bin_out <= '0;
        invalid <= 1'b1;
      end
    end else if (state == ST_SHIFT) begin
      count <= count + CNT_W'(1);
      if (last_iter) bin_out <= bin_nxt;
    end
  end

  // Shift/correct datapath; input captured at accept so later bcd_in changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      bcd_reg <= bcd_in;
      bin_reg <= '0;
    end else if (state == ST_SHIFT) begin
      bcd_reg <= bcd_nxt;
      bin_reg <= bin_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_dabble.sv
// Directed bench for bcd_to_bin_dabble against a digit-weighted BCD decode model.
module tb_bcd_to_bin_dabble;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        invalid;

  int n_vec;
  int n_bad;

  bcd_to_bin_dabble #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: weighted sum of decimal digits
  function automatic int ref_decode(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic ref_invalid(input logic [15:0] b);
    return (b[15:12] > 4'd9) || (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // Runs one conversion starting at a negedge; cyc = negedges from start until done (-1 on timeout)
  task automatic run_conv(input logic [15:0] b, output int cyc, output logic [13:0] bin,
                          output logic inv, output int busy_cnt,
                          output logic done_after, output logic busy_after);
    cyc      = -1;
    busy_cnt = 0;
    bin      = '0;
    inv      = 1'b0;
    start    = 1'b1;
    bcd_in   = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        cyc = i;
        bin = bin_out;
        inv = invalid;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bcd_in = 16'h1234;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_vec++; if (bin_out !== 14'd0) begin n_bad++; $display("FAIL reset_bin got=%0d want=0", bin_out); end
    n_vec++; if (invalid !== 1'b0)  begin n_bad++; $display("FAIL reset_invalid got=%b want=0", invalid); end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset busy got=%b want=0", busy); end
  endtask

  task automatic test_zero();
    int cyc, bc; logic [13:0] bin; logic inv, da, ba;
    run_conv(16'h0000, cyc, bin, inv, bc, da, ba);
    n_vec++; if (cyc != 15)     begin n_bad++; $display("FAIL zero_latency got=%0d want=15", cyc); end
    n_vec++; if (bin !== 14'd0) begin n_bad++; $display("FAIL zero_bin got=%0d want=0", bin); end
    n_vec++; if (inv !== 1'b0)  begin n_bad++; $display("FAIL zero_invalid got=%b want=0", inv); end
    n_vec++; if (da !== 1'b0 || ba !== 1'b0)
      begin n_bad++; $display("FAIL zero_done_pulse done=%b busy=%b want=0/0", da, ba); end
  endtask

  task automatic test_max();
    int cyc, bc; logic [13:0] bin; logic inv, da, ba;
    run_conv(16'h9999, cyc, bin, inv, bc, da, ba);
    n_vec++; if (bin !== 14'h270F) begin n_bad++; $display("FAIL max_bin got=%0d want=9999", bin); end
    n_vec++; if (bc != 15)         begin n_bad++; $display("FAIL max_busy_cycles got=%0d want=15", bc); end
    n_vec++; if (cyc != 15)        begin n_bad++; $display("FAIL max_latency got=%0d want=15", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc; logic [13:0] bin; logic inv, da, ba;
    run_conv(16'h1234, cyc, bin, inv, bc, da, ba);
    n_vec++; if (bin !== 14'h04D2) begin n_bad++; $display("FAIL b2b_first got=%0d want=1234", bin); end
    run_conv(16'h0001, cyc, bin, inv, bc, da, ba);
    n_vec++; if (bin !== 14'd1) begin n_bad++; $display("FAIL b2b_second got=%0d want=1", bin); end
    n_vec++; if (cyc != 15)     begin n_bad++; $display("FAIL b2b_latency got=%0d want=15", cyc); end
  endtask

  task automatic test_invalid();
    int cyc, bc; logic [13:0] bin; logic inv, da, ba;
    run_conv(16'h12A4, cyc, bin, inv, bc, da, ba);
    n_vec++; if (cyc != 1)      begin n_bad++; $display("FAIL inv_latency got=%0d want=1", cyc); end
    n_vec++; if (inv !== 1'b1)  begin n_bad++; $display("FAIL inv_flag got=%b want=1", inv); end
    n_vec++; if (bin !== 14'd0) begin n_bad++; $display("FAIL inv_bin got=%0d want=0", bin); end
    n_vec++; if (invalid !== 1'b1) begin n_bad++; $display("FAIL inv_held got=%b want=1", invalid); end
    run_conv(16'h0007, cyc, bin, inv, bc, da, ba);
    n_vec++; if (inv !== 1'b0 || bin !== 14'd7)
      begin n_bad++; $display("FAIL inv_cleared got inv=%b bin=%0d want 0/7", inv, bin); end
    // every illegal code in every digit position
    for (int pos = 0; pos < 4; pos++) begin
      for (int v = 10; v < 16; v++) begin
        logic [15:0] b;
        b = 16'h0358;
        b[pos*4 +: 4] = 4'(v);
        run_conv(b, cyc, bin, inv, bc, da, ba);
        n_vec++;
        if (cyc != 1 || inv !== ref_invalid(b) || bin !== 14'd0) begin
          n_bad++;
          $display("FAIL inv_sweep bcd=%h got cyc=%0d inv=%b bin=%0d want 1/1/0", b, cyc, inv, bin);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int dones, first;
    logic [13:0] bin;
    dones = 0; first = -1; bin = '0;
    start = 1'b1; bcd_in = 16'h0500;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) bcd_in = 16'h0999;
      if (done) begin
        dones++;
        if (first < 0) begin first = i; bin = bin_out; end
      end
    end
    n_vec++; if (bin !== 14'd500) begin n_bad++; $display("FAIL ignore_bin got=%0d want=500", bin); end
    n_vec++; if (dones != 1)      begin n_bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
    n_vec++; if (first != 15)     begin n_bad++; $display("FAIL ignore_latency got=%0d want=15", first); end
  endtask

  task automatic test_reset_abort();
    int cyc, bc, dones; logic [13:0] bin; logic inv, da, ba;
    start = 1'b1; bcd_in = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    n_vec++; if (bin_out !== 14'd0) begin n_bad++; $display("FAIL abort_bin got=%0d want=0", bin_out); end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_vec++; if (dones != 0) begin n_bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    run_conv(16'h0042, cyc, bin, inv, bc, da, ba);
    n_vec++; if (bin !== 14'd42) begin n_bad++; $display("FAIL abort_restart got=%0d want=42", bin); end
  endtask

  task automatic test_sweep();
    int cyc, bc; logic [13:0] bin; logic inv, da, ba;
    logic [15:0] b;
    for (int v = 0; v <= 10000; v += 37) begin
      int val;
      val = (v > 9999) ? 9999 : v;
      b = to_bcd(val);
      run_conv(b, cyc, bin, inv, bc, da, ba);
      n_vec++;
      if (cyc != 15 || inv !== 1'b0 || bin !== 14'(ref_decode(b))) begin
        n_bad++;
        $display("FAIL sweep bcd=%h got bin=%0d inv=%b cyc=%0d want %0d/0/15",
                 b, bin, inv, cyc, ref_decode(b));
      end
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_invalid();
    test_start_ignored();
    test_reset_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
